// File: rtl/dsp_share_sched_pkg.sv
// Shared widths, latencies and the in-flight tag type
// for the DSP MAC slice scheduler.
package dsp_sched_pkg;

  localparam int A_W      = 18;
  localparam int B_W      = 18;
  localparam int C_W      = 48;
  localparam int P_W      = 48;
  localparam int DSP_LAT  = 4;
  localparam int B_SKEW   = 1;
  localparam int C_SKEW   = 2;
  localparam int TAG_ID_W = 2;

  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/dsp_share_sched_rr_arbiter.sv
// Round-robin arbiter: req + en -> one-hot gnt, index,
// any-grant flag; pointer moves past each winner.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cand;

  // Scan from the pointer upward with wrap; first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (en && rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = IDX_W'((int'(ptr_q) + k) % NREQ);
        if (!gnt_any && req[cand]) begin
          gnt_any   = 1'b1;
          gnt_idx   = cand;
          gnt[cand] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (gnt_idx == IDX_W'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dsp_share_sched.sv
// Shares one pipelined MAC slice among NREQ requesters.
// req_* in, dsp_a/b/c/d out, dsp_p in, rsp_* and busy out.
module dsp_share_sched
  import dsp_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = TAG_ID_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  input  logic [NREQ*C_W-1:0] req_c,
  output logic [A_W-1:0]    dsp_a,
  output logic [B_W-1:0]    dsp_b,
  output logic [C_W-1:0]    dsp_c,
  output logic [A_W-1:0]    dsp_d,
  input  logic [P_W-1:0]    dsp_p,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [P_W-1:0]    rsp_p,
  output logic              busy
);

  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_any;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  logic [A_W-1:0] sel_a;
  logic [B_W-1:0] sel_b;
  logic [C_W-1:0] sel_c;

  always_comb begin
    sel_a = req_a[gnt_idx*A_W +: A_W];
    sel_b = req_b[gnt_idx*B_W +: B_W];
    sel_c = req_c[gnt_idx*C_W +: C_W];
  end

  logic [A_W-1:0]             dsp_a_q, dsp_a_d;
  logic [B_SKEW-1:0][B_W-1:0] b_sk_q, b_sk_d;
  logic [B_W-1:0]             dsp_b_q, dsp_b_d;
  logic [C_SKEW-1:0][C_W-1:0] c_sk_q, c_sk_d;
  logic [C_W-1:0]             dsp_c_q, dsp_c_d;
  tag_t [DSP_LAT-1:0]         tag_q, tag_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]            rsp_id_q, rsp_id_d;

  // Empty slots carry zeros so idle slice inputs stay
  // deterministic; B and C lag A to match the slice's
  // deeper input registers on A.
  always_comb begin
    dsp_a_d   = gnt_any ? sel_a : '0;
    b_sk_d[0] = gnt_any ? sel_b : '0;
    for (int i = 1; i < B_SKEW; i++) begin
      b_sk_d[i] = b_sk_q[i-1];
    end
    dsp_b_d   = b_sk_q[B_SKEW-1];
    c_sk_d[0] = gnt_any ? sel_c : '0;
    for (int i = 1; i < C_SKEW; i++) begin
      c_sk_d[i] = c_sk_q[i-1];
    end
    dsp_c_d   = c_sk_q[C_SKEW-1];
    tag_d[0].v  = gnt_any;
    tag_d[0].id = TAG_ID_W'(gnt_idx);
    for (int s = 1; s < DSP_LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
    rsp_valid_d = tag_q[DSP_LAT-1].v;
    rsp_id_d    = ID_W'(tag_q[DSP_LAT-1].id);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_a_q     <= '0;
      b_sk_q      <= '0;
      dsp_b_q     <= '0;
      c_sk_q      <= '0;
      dsp_c_q     <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      dsp_a_q     <= dsp_a_d;
      b_sk_q      <= b_sk_d;
      dsp_b_q     <= dsp_b_d;
      c_sk_q      <= c_sk_d;
      dsp_c_q     <= dsp_c_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // A same-cycle grant counts as busy so busy=0 always
  // means nothing is headed into the slice.
  always_comb begin
    busy = gnt_any;
    for (int s = 0; s < DSP_LAT; s++) begin
      busy = busy | tag_q[s].v;
    end
  end

  assign dsp_a     = dsp_a_q;
  assign dsp_b     = dsp_b_q;
  assign dsp_c     = dsp_c_q;
  assign dsp_d     = '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = dsp_p;

endmodule

// File: tb/tb_dsp_share_sched.sv
// Bench for dsp_share_sched with an ADD-mode MAC slice
// model; queue-based reference plus directed sequences.
module tb_dsp_share_sched;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*18-1:0] req_a;
  logic [NREQ*18-1:0] req_b;
  logic [NREQ*48-1:0] req_c;
  logic [17:0]       dsp_a, dsp_b, dsp_d;
  logic [47:0]       dsp_c, dsp_p, rsp_p;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic              busy;

  logic [17:0] op_a [NREQ];
  logic [17:0] op_b [NREQ];
  logic [47:0] op_c [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*18 +: 18] = op_a[i];
      req_b[i*18 +: 18] = op_b[i];
      req_c[i*48 +: 48] = op_c[i];
    end
  end

  dsp_share_sched #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
    .dsp_c     (dsp_c),
    .dsp_d     (dsp_d),
    .dsp_p     (dsp_p),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  // Slice stand-in: A 2 regs, B 1 reg, M reg, C 1 reg, P.
  logic [17:0] s_a1, s_a2, s_b1;
  logic [47:0] s_m, s_c1, s_p;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_a1 <= '0; s_a2 <= '0; s_b1 <= '0;
      s_m  <= '0; s_c1 <= '0; s_p  <= '0;
    end else begin
      s_a1 <= dsp_a;
      s_a2 <= s_a1;
      s_b1 <= dsp_b;
      s_m  <= 48'(s_a2) * 48'(s_b1);
      s_c1 <= dsp_c;
      s_p  <= s_m + s_c1;
    end
  end
  assign dsp_p = s_p;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void check(string nm,
                                logic [63:0] act,
                                logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endfunction

  typedef struct {
    int          due;
    int          id;
    logic [47:0] p;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          m_ptr = 0;
  logic [47:0] obs_p[$];
  int          obs_id[$];
  logic [NREQ-1:0] smp_rdy;
  logic        smp_rv;
  logic [47:0] smp_p;
  logic        smp_busy;

  // Winner = valid requester at smallest forward distance
  // from the pointer.
  function automatic logic [NREQ-1:0] rr_expect(
    int ptr, logic [NREQ-1:0] v, logic e, logic r);
    logic [NREQ-1:0] res = '0;
    int best = NREQ;
    int bi = 0;
    int d;
    if (e && r) begin
      for (int i = 0; i < NREQ; i++) begin
        if (v[i]) begin
          d = (i - ptr + NREQ) % NREQ;
          if (d < best) begin
            best = d;
            bi = i;
          end
        end
      end
    end
    if (best < NREQ) res[bi] = 1'b1;
    return res;
  endfunction

  // Called at a negedge with inputs driven; checks this
  // cycle, crosses one posedge, returns at next negedge.
  task automatic cycle();
    logic [NREQ-1:0] eg;
    logic            erv;
    logic [47:0]     ep;
    int              gi;
    #1;
    eg = rr_expect(m_ptr, req_valid, en, rst_n);
    check("req_ready", 64'(req_ready), 64'(eg));
    erv = (q.size() > 0) && (q[0].due == cyc);
    check("rsp_valid", 64'(rsp_valid), 64'(erv));
    if (erv) begin
      check("rsp_id", 64'(rsp_id), 64'(q[0].id));
      check("rsp_p", 64'(rsp_p), 64'(q[0].p));
    end
    while (q.size() > 0 && q[0].due <= cyc)
      void'(q.pop_front());
    check("busy", 64'(busy),
          64'((|eg) || (q.size() > 0)));
    check("dsp_d", 64'(dsp_d), 64'(0));
    smp_rdy  = req_ready;
    smp_rv   = rsp_valid;
    smp_p    = rsp_p;
    smp_busy = busy;
    if (rsp_valid) begin
      obs_p.push_back(rsp_p);
      obs_id.push_back(int'(rsp_id));
    end
    gi = -1;
    ep = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (eg[i]) begin
        gi = i;
        ep = 48'(op_a[i]) * 48'(op_b[i]) + op_c[i];
      end
    end
    @(posedge clk);
    cyc++;
    if (gi >= 0) begin
      q.push_back('{due: cyc + 4, id: gi, p: ep});
      m_ptr = (gi + 1) % NREQ;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    m_ptr = 0;
    #1;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_dsp_abc",
          64'(dsp_a) | 64'(dsp_b) | 64'(dsp_c), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) cycle();
  endtask

  task automatic set_op(input int i, input logic [17:0] a,
                        input logic [17:0] b,
                        input logic [47:0] c);
    op_a[i] = a;
    op_b[i] = b;
    op_c[i] = c;
  endtask

  typedef struct {
    logic            en;
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] rdy;
  } vec_t;

  vec_t tbl[16];
  int   nrv;

  initial begin
    tbl[0]  = '{1'b1, 4'b1111, 4'b0001};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0010};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0100};
    tbl[3]  = '{1'b1, 4'b1111, 4'b1000};
    tbl[4]  = '{1'b1, 4'b1111, 4'b0001};
    tbl[5]  = '{1'b1, 4'b1111, 4'b0010};
    tbl[6]  = '{1'b1, 4'b1111, 4'b0100};
    tbl[7]  = '{1'b1, 4'b1111, 4'b1000};
    tbl[8]  = '{1'b0, 4'b1111, 4'b0000};
    tbl[9]  = '{1'b1, 4'b0000, 4'b0000};
    tbl[10] = '{1'b1, 4'b0110, 4'b0010};
    tbl[11] = '{1'b1, 4'b0010, 4'b0010};
    tbl[12] = '{1'b1, 4'b1001, 4'b1000};
    tbl[13] = '{1'b1, 4'b1001, 4'b0001};
    tbl[14] = '{1'b1, 4'b1100, 4'b0100};
    tbl[15] = '{1'b1, 4'b0101, 4'b0001};
    for (int i = 0; i < NREQ; i++) set_op(i, 0, 0, 0);

    @(negedge clk);
    do_reset();

    // Single op from req0.
    en = 1'b1;
    set_op(0, 3, 5, 7);
    req_valid = 4'b0001;
    cycle();
    nrv = 0;
    req_valid = '0;
    repeat (4) begin
      cycle();
      if (smp_rv) nrv++;
    end
    check("single_early", 64'(nrv), 64'(0));
    cycle();
    check("single_rv", 64'(smp_rv), 64'(1));
    check("single_p", 64'(smp_p), 64'(22));
    cycle();
    check("single_pulse", 64'(smp_rv), 64'(0));
    idle(2);

    // Arbitration table from pointer 0.
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_op(i, 18'(i + 1), 18'(i + 10), 48'(i * 7));
    obs_id.delete();
    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en;
      req_valid = tbl[i].v;
      cycle();
      check($sformatf("tbl_rdy[%0d]", i),
            64'(smp_rdy), 64'(tbl[i].rdy));
    end
    en = 1'b1;
    idle(6);
    for (int i = 0; i < 8; i++)
      check($sformatf("rr_id[%0d]", i),
            64'(obs_id[i]), 64'(i % 4));

    // Back-to-back from req2.
    obs_p.delete();
    for (int k = 1; k <= 4; k++) begin
      set_op(2, 18'(k), 2, 100);
      req_valid = 4'b0100;
      cycle();
    end
    idle(6);
    check("b2b_cnt", 64'(obs_p.size()), 64'(4));
    for (int k = 0; k < 4 && k < obs_p.size(); k++)
      check($sformatf("b2b_p[%0d]", k),
            64'(obs_p[k]), 64'(102 + 2 * k));

    // en drops after two grants.
    obs_p.delete();
    req_valid = 4'b1111;
    repeat (2) cycle();
    en = 1'b0;
    repeat (7) cycle();
    check("en_off_cnt", 64'(obs_p.size()), 64'(2));
    check("en_off_busy", 64'(smp_busy), 64'(0));
    en = 1'b1;
    idle(1);

    // Reset mid-burst.
    do_reset();
    req_valid = 4'b1110;
    repeat (3) cycle();
    do_reset();
    obs_p.delete();
    idle(7);
    check("rst_lost", 64'(obs_p.size()), 64'(0));
    req_valid = 4'b1111;
    cycle();
    check("post_rst_gnt", 64'(smp_rdy), 64'(1));
    idle(6);

    // Maximum operands wrap at 48 bits.
    obs_p.delete();
    set_op(3, 18'h3FFFF, 18'h3FFFF, 48'hFFFF_FFFF_FFFF);
    req_valid = 4'b1000;
    cycle();
    idle(6);
    check("max_cnt", 64'(obs_p.size()), 64'(1));
    if (obs_p.size() > 0)
      check("max_p", 64'(obs_p[0]),
            64'(48'h000F_FFF8_0000));

    // Randomised traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(9) != 0);
      req_valid = 4'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_op(i, 18'($urandom), 18'($urandom),
               {16'($urandom), 32'($urandom)});
      cycle();
    end
    en = 1'b1;
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
